seg_display: RTL and testbench
==============================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 64..2^20-1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port min, input, 7, minutes count in binary.
REQ-005 The block SHALL have port sec, input, 7, seconds count in binary.
REQ-006 The block SHALL have port ms, input, 7, centiseconds count in binary.
REQ-007 The block SHALL have port an, output, 8, digit anodes, active-low, an[0] is the rightmost digit.
REQ-008 The block SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-009 The block SHALL have port dp, output, 1, decimal point, active-low.
REQ-010 The block SHALL have port busy, output, 1, high while a BCD conversion is in progress.

Function
REQ-011 Divider: cnt counts 0..REFRESH_DIV-1 and wraps; strobe is asserted when cnt==REFRESH_DIV-1; scan index idx (3 bits) increments on strobe and wraps 7->0.
REQ-012 Capture: min/sec/ms SHALL be latched into snapshot registers on strobe with idx==7, and on the first cycle after rst deasserts; inputs SHALL be ignored at all other times.
REQ-013 Overflow flag: at capture, each field SHALL set its own flag if its value is >99.
REQ-014 Converter FSM states: IDLE, CONV, DONE; capture moves IDLE->CONV; a capture arriving outside IDLE SHALL be dropped.
REQ-015 CONV: fields are processed in order ms, sec, min; per cycle, if rem>=10 then rem-=10 and tens++; otherwise store tens and rem for the field, then advance to the next field or to DONE after min.
REQ-016 Conversion length: the CONV state SHALL last sum over fields of (tens+1) cycles; for an overflowed field, tens saturates, and conversion stops at 9 with the field shown as dashes.
REQ-017 DONE SHALL copy all six BCD digits and three overflow flags to the display registers in one cycle and then return to IDLE; the display SHALL never show a mix of old and new values.
REQ-018 busy SHALL be high exactly while the state is CONV or DONE.
REQ-019 Digit map by idx:
  - 0 = ms ones, 1 = ms tens
  - 2 = sec ones, 3 = sec tens
  - 4 = min ones, 5 = min tens
  - 6, 7 = blank (an all 1)
REQ-020 For idx 0..5, an SHALL have only bit idx low; seg SHALL show standard hex-0..9 patterns (0=7'b1000000, 1=7'b1111001, ..., 9=7'b0010000); there is no leading-zero suppression.
REQ-021 An overflowed field SHALL show dash (7'b0111111) on both of its digits.
REQ-022 dp SHALL be low on idx 2 and 4 (separators) and high on all other slots.
REQ-023 an, seg and dp SHALL be registered, lagging idx and the display registers by one cycle.

Reset
REQ-024 While rst is high, the block SHALL hold:
  - cnt=0, idx=0, state IDLE, busy=0
  - snapshot, BCD and display registers = 0, overflow flags = 0
  - an=8'hFF, seg=7'h7F, dp=1
REQ-025 After rst deasserts, the outputs SHALL scan the display registers normally, with capture per REQ-012.
REQ-026 rst asserted mid-conversion SHALL abort the conversion and apply REQ-024 on the next edge.

Verification
REQ-027 Reset: hold rst for 2 cycles -> an=8'hFF, seg=7'h7F, dp=1, busy=0.
REQ-028 Basic display: REFRESH_DIV=64, min=12, sec=34, ms=56 at reset release -> after busy falls, slots 0..5 show 6,5,4,3,2,1; slot 5 has an=8'hDF and seg=7'b1111001; dp is low only on slots 2 and 4.
REQ-029 Busy length: inputs all 0 -> busy high for 4 cycles; inputs all 99 -> busy high for 31 cycles.
REQ-030 Overflow: sec=100, min=5, ms=7 -> slots 2 and 3 show 7'b0111111; the other digits show 07 and 05.
REQ-031 Mid-frame change: change ms from 10 to 20 at idx=3 -> display holds 10 until the idx==7 strobe, then shows 20 after the next conversion.
REQ-032 Reset mid-conversion: assert rst while busy=1 -> next cycle busy=0, an=8'hFF, and the display registers are 0.

Source files
------------

// File: rtl/seg_display.sv
// seg_display
// Eight-digit multiplexed seven-segment driver for a MM:SS.cc stopwatch
// readout. The binary min/sec/ms inputs are sampled once per scan frame,
// converted to BCD by repeated subtraction, and then swapped into the
// display registers in a single cycle, so a frame never shows a mix of
// old and new digits.
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   min   : minutes, binary (values above 99 are shown as dashes)
//   sec   : seconds, binary (values above 99 are shown as dashes)
//   ms    : centiseconds, binary (values above 99 are shown as dashes)
//   an    : digit anodes, active-low, an[0] is the rightmost digit
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low, lit on the separator slots 2 and 4
//   busy  : high while a BCD conversion is in progress
module seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    input  logic [6:0] ms,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q;
    logic [2:0]  idx_q;
    logic        firstCycle_q;
    logic [6:0]  snapMin_q, snapSec_q;
    logic        ovfMin_q, ovfSec_q, ovfMs_q;
    logic [6:0]  rem_q;
    logic [3:0]  tens_q;
    logic [1:0]  field_q;
    logic [3:0]  bcdMsOnes_q, bcdMsTens_q, bcdSecOnes_q, bcdSecTens_q;
    logic [3:0]  bcdMinOnes_q, bcdMinTens_q;
    logic [3:0]  dispMsOnes_q, dispMsTens_q, dispSecOnes_q, dispSecTens_q;
    logic [3:0]  dispMinOnes_q, dispMinTens_q;
    logic        dispOvfMin_q, dispOvfSec_q, dispOvfMs_q;
    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;

    logic        strobe;
    logic        capture;
    logic        captureAccept;
    logic        stepTen;
    logic [3:0]  digitSel;
    logic        dashSel;
    logic        blankSel;
    logic [7:0]  anNext;
    logic [6:0]  segNext;
    logic        dpNext;

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        case (d)
            4'd0:    decodeDigit = 7'b1000000;
            4'd1:    decodeDigit = 7'b1111001;
            4'd2:    decodeDigit = 7'b0100100;
            4'd3:    decodeDigit = 7'b0110000;
            4'd4:    decodeDigit = 7'b0011001;
            4'd5:    decodeDigit = 7'b0010010;
            4'd6:    decodeDigit = 7'b0000010;
            4'd7:    decodeDigit = 7'b1111000;
            4'd8:    decodeDigit = 7'b0000000;
            4'd9:    decodeDigit = 7'b0010000;
            default: decodeDigit = 7'b1111111;
        endcase
    endfunction

    assign strobe  = (cnt_q == CNT_MAX);
    // A new sample is taken once per frame (last slot's strobe) and right
    // after reset so the display does not sit at zero for a whole frame.
    assign capture = firstCycle_q | (strobe & (idx_q == 3'd7));
    // Samples arriving while a conversion is still running are dropped.
    assign captureAccept = capture & (state_q == IDLE);
    // Subtract another ten unless the field is done; tens saturates at 9,
    // which bounds the work on an overflowed field.
    assign stepTen = (rem_q >= 7'd10) && (tens_q != 4'd9);

    // Refresh divider and scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            firstCycle_q <= 1'b1;
        end else begin
            firstCycle_q <= 1'b0;
            if (strobe) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + 20'd1;
            end
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter next-state logic: ms, sec, min are handled in turn and the
    // last store of the min field hands over to the display copy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (captureAccept) state_d = CONV;
            CONV: if (!stepTen && (field_q == 2'd2)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Converter outputs.
    always_comb begin
        busy = (state_q == CONV) || (state_q == DONE);
    end

    // Snapshot, overflow flags and the subtract-by-ten datapath. ms goes
    // straight into the working remainder at capture, so only sec and min
    // need holding until their turn comes.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapMin_q    <= '0;
            snapSec_q    <= '0;
            ovfMin_q     <= 1'b0;
            ovfSec_q     <= 1'b0;
            ovfMs_q      <= 1'b0;
            rem_q        <= '0;
            tens_q       <= '0;
            field_q      <= '0;
            bcdMsOnes_q  <= '0;
            bcdMsTens_q  <= '0;
            bcdSecOnes_q <= '0;
            bcdSecTens_q <= '0;
            bcdMinOnes_q <= '0;
            bcdMinTens_q <= '0;
        end else if (captureAccept) begin
            snapMin_q <= min;
            snapSec_q <= sec;
            ovfMin_q  <= (min > 7'd99);
            ovfSec_q  <= (sec > 7'd99);
            ovfMs_q   <= (ms > 7'd99);
            rem_q     <= ms;
            tens_q    <= '0;
            field_q   <= '0;
        end else if (state_q == CONV) begin
            if (stepTen) begin
                rem_q  <= rem_q - 7'd10;
                tens_q <= tens_q + 4'd1;
            end else begin
                case (field_q)
                    2'd0: begin
                        bcdMsOnes_q <= rem_q[3:0];
                        bcdMsTens_q <= tens_q;
                        rem_q       <= snapSec_q;
                    end
                    2'd1: begin
                        bcdSecOnes_q <= rem_q[3:0];
                        bcdSecTens_q <= tens_q;
                        rem_q        <= snapMin_q;
                    end
                    default: begin
                        bcdMinOnes_q <= rem_q[3:0];
                        bcdMinTens_q <= tens_q;
                    end
                endcase
                tens_q  <= '0;
                field_q <= field_q + 2'd1;
            end
        end
    end

    // Display registers change only in DONE, all at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            dispMsOnes_q  <= '0;
            dispMsTens_q  <= '0;
            dispSecOnes_q <= '0;
            dispSecTens_q <= '0;
            dispMinOnes_q <= '0;
            dispMinTens_q <= '0;
            dispOvfMin_q  <= 1'b0;
            dispOvfSec_q  <= 1'b0;
            dispOvfMs_q   <= 1'b0;
        end else if (state_q == DONE) begin
            dispMsOnes_q  <= bcdMsOnes_q;
            dispMsTens_q  <= bcdMsTens_q;
            dispSecOnes_q <= bcdSecOnes_q;
            dispSecTens_q <= bcdSecTens_q;
            dispMinOnes_q <= bcdMinOnes_q;
            dispMinTens_q <= bcdMinTens_q;
            dispOvfMin_q  <= ovfMin_q;
            dispOvfSec_q  <= ovfSec_q;
            dispOvfMs_q   <= ovfMs_q;
        end
    end

    // Slot decode: pick the digit for the current scan index.
    always_comb begin
        digitSel = '0;
        dashSel  = 1'b0;
        blankSel = 1'b0;
        case (idx_q)
            3'd0: begin digitSel = dispMsOnes_q;  dashSel = dispOvfMs_q;  end
            3'd1: begin digitSel = dispMsTens_q;  dashSel = dispOvfMs_q;  end
            3'd2: begin digitSel = dispSecOnes_q; dashSel = dispOvfSec_q; end
            3'd3: begin digitSel = dispSecTens_q; dashSel = dispOvfSec_q; end
            3'd4: begin digitSel = dispMinOnes_q; dashSel = dispOvfMin_q; end
            3'd5: begin digitSel = dispMinTens_q; dashSel = dispOvfMin_q; end
            default: blankSel = 1'b1;
        endcase
        anNext  = blankSel ? 8'hFF : ~(8'd1 << idx_q);
        segNext = dashSel ? 7'b0111111 : decodeDigit(digitSel);
        dpNext  = !((idx_q == 3'd2) || (idx_q == 3'd4));
    end

    // Registered pin drivers, one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= anNext;
            seg_q <= segNext;
            dp_q  <= dpNext;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display
// Self-checking bench for seg_display with a 64-cycle refresh divider.
// A behavioural model tracks time since reset release, works out which
// slot is being shown, when samples are taken, how long a conversion
// takes from the field values, and which values the display holds, and
// every cycle compares an/seg/dp/busy against it.
module tb_seg_display;

    localparam int DIV   = 64;
    localparam int FRAME = DIV * 8;

    logic       clk;
    logic       rst;
    logic [6:0] minIn, secIn, msIn;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int errors;
    int checks;

    int n;
    int capEdge;
    int busyLen;
    int busyCount;
    int pendMin, pendSec, pendMs;
    int dispMin, dispSec, dispMs;
    int prevMin, prevSec, prevMs;

    logic [6:0] segTable [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .min  (minIn),
        .sec  (secIn),
        .ms   (msIn),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at n=%0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Cycles one field needs: one per ten removed plus a store cycle,
    // with overflowed fields capped at nine tens.
    function automatic int fieldCycles(input int v);
        return (v > 99) ? 10 : (v / 10 + 1);
    endfunction

    function automatic int busyCycles(input int m, input int s, input int c);
        return fieldCycles(m) + fieldCycles(s) + fieldCycles(c) + 1;
    endfunction

    function automatic logic [6:0] expSeg(input int slot, input int m,
                                          input int s, input int c);
        int v;
        v = (slot < 2) ? c : ((slot < 4) ? s : m);
        if (v > 99) return 7'b0111111;
        return segTable[(slot % 2 == 1) ? (v / 10) : (v % 10)];
    endfunction

    // One clock: update the model for this edge, then compare at negedge.
    task automatic stepCycle();
        int slot;
        logic [7:0] expAn;
        logic expDp;
        logic expBusy;
        @(posedge clk);
        n++;
        prevMin = dispMin;
        prevSec = dispSec;
        prevMs  = dispMs;
        if ((n == 1 || n % FRAME == 0) &&
            !(capEdge > 0 && n < capEdge + busyLen)) begin
            capEdge = n;
            busyLen = busyCycles(minIn, secIn, msIn);
            pendMin = minIn;
            pendSec = secIn;
            pendMs  = msIn;
        end
        if (capEdge > 0 && n == capEdge + busyLen) begin
            dispMin = pendMin;
            dispSec = pendSec;
            dispMs  = pendMs;
        end
        @(negedge clk);
        slot    = ((n - 1) / DIV) % 8;
        expAn   = (slot < 6) ? ~(8'd1 << slot) : 8'hFF;
        expDp   = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
        expBusy = (capEdge > 0 && n >= capEdge && n < capEdge + busyLen);
        checkOutput("an", an, expAn);
        if (slot < 6) checkOutput("seg", seg, expSeg(slot, prevMin, prevSec, prevMs));
        checkOutput("dp", dp, expDp);
        checkOutput("busy", busy, expBusy);
        if (busy) busyCount++;
    endtask

    task automatic applyStimulus(input int cycles, input bit randomChanges);
        for (int i = 0; i < cycles; i++) begin
            stepCycle();
            if (randomChanges && $urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 2))
                    0:       minIn = 7'($urandom_range(0, 127));
                    1:       secIn = 7'($urandom_range(0, 127));
                    default: msIn  = 7'($urandom_range(0, 127));
                endcase
            end
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        checkOutput("rstAn", an, 8'hFF);
        checkOutput("rstSeg", seg, 7'h7F);
        checkOutput("rstDp", dp, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        rst       = 1'b0;
        n         = 0;
        capEdge   = 0;
        busyLen   = 0;
        busyCount = 0;
        dispMin   = 0;
        dispSec   = 0;
        dispMs    = 0;
    endtask

    task automatic setInputs(input int m, input int s, input int c);
        minIn = 7'(m);
        secIn = 7'(s);
        msIn  = 7'(c);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        setInputs(0, 0, 0);
        @(negedge clk);

        // Basic readout 12:34.56, including the per-frame resample.
        setInputs(12, 34, 56);
        doReset(2);
        applyStimulus(FRAME + 88, 1'b0);

        // Shortest and longest conversions.
        setInputs(0, 0, 0);
        doReset(2);
        applyStimulus(40, 1'b0);
        checkOutput("busyLen0", busyCount, 4);

        setInputs(99, 99, 99);
        doReset(2);
        applyStimulus(40, 1'b0);
        checkOutput("busyLen99", busyCount, 31);

        // Overflowed seconds shows dashes on both second digits.
        setInputs(5, 100, 7);
        doReset(2);
        applyStimulus(300, 1'b0);

        // Input change mid-frame must wait for the next frame sample.
        setInputs(0, 0, 10);
        doReset(2);
        applyStimulus(3 * DIV + 8, 1'b0);
        msIn = 7'd20;
        applyStimulus(FRAME, 1'b0);

        // Reset during a conversion clears everything on the next edge.
        setInputs(12, 34, 56);
        doReset(2);
        applyStimulus(FRAME + 2, 1'b0);
        checkOutput("midBusy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortAn", an, 8'hFF);
        checkOutput("abortSeg", seg, 7'h7F);
        checkOutput("abortDp", dp, 1'b1);
        doReset(1);
        applyStimulus(100, 1'b0);

        // Random values, including overflow, with random mid-run changes.
        for (int t = 0; t < 6; t++) begin
            setInputs($urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127));
            doReset(2);
            applyStimulus(2 * FRAME + 80, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
